ahb_slave_decode_ctrl: RTL and testbench
========================================

# ahb_slave_decode_ctrl

Registered, parametrised address-phase decoder and response controller for the AHB-Lite slave. It captures each AHB-Lite address phase, classifies it against the slave register map, checks alignment, size and access direction, and drives a one-cycle request strobe with byte enables into the register/FIFO logic. Illegal accesses get the standard two-cycle AHB ERROR response.

## Interface
- ADDR_W, 4: width of `haddr` (≥4).
- STATUS_ADDR, 4: base of the 16-bit status register (bytes STATUS_ADDR, STATUS_ADDR+1).
- ERROR_ADDR, 6: base of the 16-bit read-only error register.
- OCCUP_ADDR, 8: byte address of the read-only buffer occupancy register.
- TXCTRL_ADDR, 12: byte address of the R/W TX control register.
- FLUSH_ADDR, 13: byte address of the flush register (R/W).
- RO_WRITE_ERR, 1: 1 = writes to read-only registers produce ERROR; 0 = accepted with `req_valid` but `req_write` forced 0.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  transfer address.
- hsize  in  3  transfer size (0 byte, 1 halfword, 2 word).
- htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- hwrite  in  1  1 = write.
- hready  in  1  bus ready (system-level, normally tied to `hreadyout`).
- hreadyout  out  1  slave ready.
- hresp  out  1  1 = ERROR.
- req_valid  out  1  one-cycle strobe in the data phase of a legal transfer.
- req_write  out  1  direction qualifier for `req_valid`.
- value_location  out  4  decoded target code.
- byte_en  out  4  byte lanes of the data bus used by the transfer.

## Operation
- Accept: `hsel & htrans[1] & hready` at a rising edge latches `haddr`, `hsize`, `hwrite` and the decode result. Otherwise, including IDLE/BUSY: no request, OKAY.
- Target codes: BUFFER4=0, BUFFER2=2, BUFFER1=3, STATUS=4, STATUS_LOWER=5, STATUS_UPPER=6, ERROR=7, ERROR_LOWER=8, ERROR_UPPER=9, TX_CONTROL=10, FLUSH_BUFFER=11, BUFFER_OCCUP=12, NONE=15. Code 1 is reserved and never produced.
- Buffer window, addresses 0–3, R/W:
  - Word requires `haddr[1:0]==0` and gives BUFFER4.
  - Halfword requires `haddr[0]==0` and gives BUFFER2.
  - Byte gives BUFFER1.
- Status and error registers:
  - Halfword at base gives STATUS or ERROR.
  - Byte at base gives the _LOWER code; byte at base+1 gives the _UPPER code.
  - Word access, or halfword at base+1, is illegal.
- Error register and OCCUP are read-only. TXCTRL and FLUSH are byte-only.
- Illegal, all giving ERROR: unmapped address, `hsize>2`, misalignment, wrong size, or RO write when RO_WRITE_ERR=1.
- `byte_en`: lanes from `haddr[1:0]` and size, e.g. byte@5 = 4'b0010, halfword@2 = 4'b1100, word = 4'b1111. It is 0 when no request is issued.
- FSM states:
  - IDLE: legal accept gives OKAY, stays in IDLE. Illegal accept goes to ERR1.
  - ERR1: `hreadyout=0`, `hresp=1`, no request; always goes to ERR2.
  - ERR2: `hreadyout=1`, `hresp=1`. Goes to IDLE. A new accept in this cycle is decoded normally and may go straight to ERR1.

## Timing
- Reset values, for all outputs when `rst`=1 at an edge: `hreadyout`=1, `hresp`=0, `req_valid`=0, `req_write`=0, `value_location`=15, `byte_en`=0, FSM in IDLE.
- Reset during ERR1/ERR2 aborts the error and takes the reset values on the next cycle.
- Legal transfer, zero wait states:
  - In the cycle after the accepting edge, `req_valid`=1 with `value_location`/`byte_en`/`req_write` valid.
  - `value_location` returns to 15 the following cycle unless a new transfer was accepted.
- Back-to-back legal transfers give `req_valid` high on consecutive cycles.
- Error: data phase is two cycles (ERR1, ERR2). The next address phase can only be accepted at the edge ending ERR2, because `hready` is low in ERR1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- After reset: `hreadyout`=1, `hresp`=0, `value_location`=15, `byte_en`=0.
- Word write @0 with htrans=2 → next cycle `req_valid`=1, `req_write`=1, `value_location`=0, `byte_en`=4'b1111, `hresp`=0.
- Back-to-back: byte read @5, then halfword read @6 → two consecutive `req_valid` pulses: first code 6 with `byte_en` 4'b0010, then code 7 with `byte_en` 4'b1100.
- Word read @2 (misaligned) → `hreadyout`=0/`hresp`=1, then `hreadyout`=1/`hresp`=1, `req_valid` never asserted. Repeat with write @8 with RO_WRITE_ERR=1 and with an access @15 → same response.
- With RO_WRITE_ERR=0, byte write @8 → `req_valid`=1, `req_write`=0, code 12, OKAY.
- `rst` asserted in ERR1 → next cycle `hreadyout`=1, `hresp`=0. Also, htrans=0 with `hsel`=1 → no `req_valid`, OKAY.

Source files
------------

// File: rtl/ahb_slave_decode_ctrl.sv
// ----------------------------------------------------------------------------
// ahb_slave_decode_ctrl
//
// Registered address-phase decoder and response controller for an AHB-Lite
// slave. Each accepted address phase (hsel & htrans[1] & hready) is classified
// against the slave register map. Legal transfers produce a one-cycle request
// strobe (req_valid_o) in the data phase, together with the target code,
// direction and byte lanes. Illegal transfers get the two-cycle AHB ERROR
// response (hreadyout low + hresp high, then hreadyout high + hresp high).
//
// Ports
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   hsel_i            slave select
//   haddr_i           transfer address (ADDR_W bits)
//   hsize_i           transfer size: 0 byte, 1 halfword, 2 word
//   htrans_i          transfer type; bit 1 set means NONSEQ/SEQ
//   hwrite_i          1 = write
//   hready_i          bus ready (normally tied to hreadyout_o)
//   hreadyout_o       slave ready
//   hresp_o           1 = ERROR
//   req_valid_o       one-cycle request strobe for a legal transfer
//   req_write_o       direction qualifier for req_valid_o
//   value_location_o  decoded target code (15 = none)
//   byte_en_o         data-bus byte lanes used by the transfer
//
// All outputs come straight from flops; nothing on the input side reaches an
// output without passing through a register.
// ----------------------------------------------------------------------------
module ahb_slave_decode_ctrl #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned STATUS_ADDR  = 4,
  parameter int unsigned ERROR_ADDR   = 6,
  parameter int unsigned OCCUP_ADDR   = 8,
  parameter int unsigned TXCTRL_ADDR  = 12,
  parameter int unsigned FLUSH_ADDR   = 13,
  parameter bit          RO_WRITE_ERR = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hsel_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [2:0]        hsize_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic              req_valid_o,
  output logic              req_write_o,
  output logic [3:0]        value_location_o,
  output logic [3:0]        byte_en_o
);

  // Target codes
  localparam logic [3:0] LOC_BUFFER4      = 4'd0;
  localparam logic [3:0] LOC_BUFFER2      = 4'd2;
  localparam logic [3:0] LOC_BUFFER1      = 4'd3;
  localparam logic [3:0] LOC_STATUS       = 4'd4;
  localparam logic [3:0] LOC_STATUS_LOWER = 4'd5;
  localparam logic [3:0] LOC_STATUS_UPPER = 4'd6;
  localparam logic [3:0] LOC_ERROR        = 4'd7;
  localparam logic [3:0] LOC_ERROR_LOWER  = 4'd8;
  localparam logic [3:0] LOC_ERROR_UPPER  = 4'd9;
  localparam logic [3:0] LOC_TX_CONTROL   = 4'd10;
  localparam logic [3:0] LOC_FLUSH_BUFFER = 4'd11;
  localparam logic [3:0] LOC_BUFFER_OCCUP = 4'd12;
  localparam logic [3:0] LOC_NONE         = 4'd15;

  // Register addresses resized to the bus width for direct comparison
  localparam logic [ADDR_W-1:0] STATUS_LO_A = ADDR_W'(STATUS_ADDR);
  localparam logic [ADDR_W-1:0] STATUS_HI_A = ADDR_W'(STATUS_ADDR + 1);
  localparam logic [ADDR_W-1:0] ERROR_LO_A  = ADDR_W'(ERROR_ADDR);
  localparam logic [ADDR_W-1:0] ERROR_HI_A  = ADDR_W'(ERROR_ADDR + 1);
  localparam logic [ADDR_W-1:0] OCCUP_A     = ADDR_W'(OCCUP_ADDR);
  localparam logic [ADDR_W-1:0] TXCTRL_A    = ADDR_W'(TXCTRL_ADDR);
  localparam logic [ADDR_W-1:0] FLUSH_A     = ADDR_W'(FLUSH_ADDR);

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t      state_q;
  logic        hreadyout_q;
  logic        hresp_q;
  logic        req_valid_q;
  logic        req_write_q;
  logic [3:0]  loc_q;
  logic [3:0]  byte_en_q;

  // Decode results for the address phase currently on the bus
  logic        accept_s;
  logic        aligned_d;
  logic [3:0]  lanes_d;
  logic [3:0]  loc_d;
  logic        ro_d;
  logic        legal_d;
  logic        write_d;

  // htrans[0] only distinguishes SEQ from NONSEQ, which this slave treats alike
  logic        htrans_unused;
  assign htrans_unused = htrans_i[0];

  assign accept_s = hsel_i & htrans_i[1] & hready_i;

  // Byte lanes and natural alignment from size and the low address bits
  always_comb begin
    lanes_d   = 4'b0000;
    aligned_d = 1'b0;
    case (hsize_i)
      SIZE_BYTE: begin
        lanes_d   = 4'b0001 << haddr_i[1:0];
        aligned_d = 1'b1;
      end
      SIZE_HALF: begin
        lanes_d   = haddr_i[1] ? 4'b1100 : 4'b0011;
        aligned_d = ~haddr_i[0];
      end
      SIZE_WORD: begin
        lanes_d   = 4'b1111;
        aligned_d = (haddr_i[1:0] == 2'b00);
      end
      default: begin
        lanes_d   = 4'b0000;
        aligned_d = 1'b0;
      end
    endcase
  end

  // Register-map lookup; a size the target does not support yields LOC_NONE
  always_comb begin
    loc_d = LOC_NONE;
    ro_d  = 1'b0;
    if (haddr_i[ADDR_W-1:2] == '0) begin
      // Buffer window: the code encodes the access width
      case (hsize_i)
        SIZE_WORD: loc_d = LOC_BUFFER4;
        SIZE_HALF: loc_d = LOC_BUFFER2;
        SIZE_BYTE: loc_d = LOC_BUFFER1;
        default:   loc_d = LOC_NONE;
      endcase
    end else if (haddr_i == STATUS_LO_A) begin
      case (hsize_i)
        SIZE_HALF: loc_d = LOC_STATUS;
        SIZE_BYTE: loc_d = LOC_STATUS_LOWER;
        default:   loc_d = LOC_NONE;
      endcase
    end else if (haddr_i == STATUS_HI_A) begin
      if (hsize_i == SIZE_BYTE) begin
        loc_d = LOC_STATUS_UPPER;
      end else begin
        loc_d = LOC_NONE;
      end
    end else if (haddr_i == ERROR_LO_A) begin
      ro_d = 1'b1;
      case (hsize_i)
        SIZE_HALF: loc_d = LOC_ERROR;
        SIZE_BYTE: loc_d = LOC_ERROR_LOWER;
        default:   loc_d = LOC_NONE;
      endcase
    end else if (haddr_i == ERROR_HI_A) begin
      ro_d = 1'b1;
      if (hsize_i == SIZE_BYTE) begin
        loc_d = LOC_ERROR_UPPER;
      end else begin
        loc_d = LOC_NONE;
      end
    end else if (haddr_i == OCCUP_A) begin
      // Single-byte register: wider accesses would spill into unmapped bytes
      ro_d = 1'b1;
      if (hsize_i == SIZE_BYTE) begin
        loc_d = LOC_BUFFER_OCCUP;
      end else begin
        loc_d = LOC_NONE;
      end
    end else if (haddr_i == TXCTRL_A) begin
      if (hsize_i == SIZE_BYTE) begin
        loc_d = LOC_TX_CONTROL;
      end else begin
        loc_d = LOC_NONE;
      end
    end else if (haddr_i == FLUSH_A) begin
      if (hsize_i == SIZE_BYTE) begin
        loc_d = LOC_FLUSH_BUFFER;
      end else begin
        loc_d = LOC_NONE;
      end
    end else begin
      loc_d = LOC_NONE;
    end
  end

  // Final legality and effective direction; accepted RO writes become reads
  always_comb begin
    legal_d = (loc_d != LOC_NONE) && aligned_d &&
              !(ro_d && hwrite_i && RO_WRITE_ERR);
    if (ro_d) begin
      write_d = 1'b0;
    end else begin
      write_d = hwrite_i;
    end
  end

  // Response FSM with registered data-phase outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      loc_q       <= LOC_NONE;
      byte_en_q   <= 4'b0000;
    end else begin
      // Quiet OKAY data phase unless a branch below says otherwise
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      loc_q       <= LOC_NONE;
      byte_en_q   <= 4'b0000;
      case (state_q)
        ST_ERR1: begin
          // Second ERROR cycle: ready again so the master can move on
          state_q <= ST_ERR2;
          hresp_q <= 1'b1;
        end
        ST_IDLE, ST_ERR2: begin
          // The edge ending ERR2 is a normal address-phase edge
          if (accept_s && legal_d) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b1;
            req_write_q <= write_d;
            loc_q       <= loc_d;
            byte_en_q   <= lanes_d;
          end else if (accept_s) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign hreadyout_o      = hreadyout_q;
  assign hresp_o          = hresp_q;
  assign req_valid_o      = req_valid_q;
  assign req_write_o      = req_write_q;
  assign value_location_o = loc_q;
  assign byte_en_o        = byte_en_q;

endmodule

// File: tb/tb_ahb_slave_decode_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ahb_slave_decode_ctrl. Two instances share the same stimulus:
// inst A with RO_WRITE_ERR=1, inst B with RO_WRITE_ERR=0. Each instance's
// hready is tied to its own hreadyout. A register-map reference model predicts
// every output on every cycle; directed literal expectations pin the model.
// Output vector layout: {hreadyout, hresp, req_valid, req_write, loc[3:0], be[3:0]}
// ----------------------------------------------------------------------------
module tb_ahb_slave_decode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsel;
  logic [3:0] haddr;
  logic [2:0] hsize;
  logic [1:0] htrans;
  logic       hwrite;

  logic       hready_a, hresp_a, rv_a, rw_a;
  logic [3:0] vl_a, be_a;
  logic       hready_b, hresp_b, rv_b, rw_b;
  logic [3:0] vl_b, be_b;
  logic       hreadyout_a, hreadyout_b;

  assign hready_a = hreadyout_a;
  assign hready_b = hreadyout_b;

  always #5 clk = ~clk;

  ahb_slave_decode_ctrl #(.RO_WRITE_ERR(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .haddr_i(haddr), .hsize_i(hsize),
    .htrans_i(htrans), .hwrite_i(hwrite), .hready_i(hready_a),
    .hreadyout_o(hreadyout_a), .hresp_o(hresp_a), .req_valid_o(rv_a),
    .req_write_o(rw_a), .value_location_o(vl_a), .byte_en_o(be_a)
  );

  ahb_slave_decode_ctrl #(.RO_WRITE_ERR(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .haddr_i(haddr), .hsize_i(hsize),
    .htrans_i(htrans), .hwrite_i(hwrite), .hready_i(hready_b),
    .hreadyout_o(hreadyout_b), .hresp_o(hresp_b), .req_valid_o(rv_b),
    .req_write_o(rw_b), .value_location_o(vl_b), .byte_en_o(be_b)
  );

  logic [11:0] got_a, got_b;
  assign got_a = {hreadyout_a, hresp_a, rv_a, rw_a, vl_a, be_a};
  assign got_b = {hreadyout_b, hresp_b, rv_b, rw_b, vl_b, be_b};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       ok;
    logic       wr;
    logic [3:0] code;
    logic [3:0] be;
  } dec_t;

  // Map rules: natural alignment, the covered bytes must lie inside one register
  function automatic dec_t ref_decode(input int a, input int s, input bit w, input bit ro_err);
    dec_t r;
    int   n;
    bit   ro;
    r.ok = 1'b0; r.wr = 1'b0; r.code = 4'd15; r.be = 4'd0; ro = 1'b0;
    if (s > 2) return r;
    n = 1 << s;
    if ((a % n) != 0) return r;
    if (a + n <= 4)                    r.code = (n == 4) ? 4'd0 : (n == 2) ? 4'd2 : 4'd3;
    else if (a >= 4 && a <= 5 && n <= 2) r.code = (n == 2) ? 4'd4 : 4'(5 + a - 4);
    else if (a >= 6 && a <= 7 && n <= 2) begin r.code = (n == 2) ? 4'd7 : 4'(8 + a - 6); ro = 1'b1; end
    else if (a == 8 && n == 1)         begin r.code = 4'd12; ro = 1'b1; end
    else if (a == 12 && n == 1)        r.code = 4'd10;
    else if (a == 13 && n == 1)        r.code = 4'd11;
    else return r;
    if (ro && w && ro_err) begin r.code = 4'd15; return r; end
    r.ok = 1'b1;
    r.wr = w && !ro;
    r.be = 4'((((1 << n) - 1) << (a % 4)));
    return r;
  endfunction

  logic [11:0] m_out [2];
  int          m_err [2];   // remaining error data-phase cycles after this one
  dec_t        m_d;
  logic        m_rdy;

  // Model: advance both instances one bus cycle
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_rdy = (i == 0) ? hready_a : hready_b;
      m_d   = ref_decode(int'(haddr), int'(hsize), hwrite, i == 0);
      if (rst) begin
        m_err[i] <= 0;
        m_out[i] <= 12'h8F0;
      end else if (m_err[i] == 1) begin
        m_err[i] <= 0;
        m_out[i] <= 12'hCF0;
      end else if (hsel && htrans[1] && m_rdy && m_d.ok) begin
        m_err[i] <= 0;
        m_out[i] <= {1'b1, 1'b0, 1'b1, m_d.wr, m_d.code, m_d.be};
      end else if (hsel && htrans[1] && m_rdy) begin
        m_err[i] <= 1;
        m_out[i] <= 12'h4F0;
      end else begin
        m_err[i] <= 0;
        m_out[i] <= 12'h8F0;
      end
    end
  end

  // ---------------- checking ----------------
  int          checks = 0;
  int          errors = 0;
  logic        chk_en = 1'b0;
  int          lit_seq = 0;
  int          lit_done = 0;
  string       lit_name;
  logic        lit_use_a, lit_use_b;
  logic [11:0] lit_exp_a, lit_exp_b;

  // Single compare process: model every cycle, plus any pending literal check
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (got_a !== m_out[0]) begin
        errors++;
        $display("FAIL cycle_a t=%0t got %h exp %h", $time, got_a, m_out[0]);
      end
      checks++;
      if (got_b !== m_out[1]) begin
        errors++;
        $display("FAIL cycle_b t=%0t got %h exp %h", $time, got_b, m_out[1]);
      end
      if (lit_seq != lit_done) begin
        if (lit_use_a) begin
          checks++;
          if (got_a !== lit_exp_a) begin
            errors++;
            $display("FAIL %s inst A got %h exp %h", lit_name, got_a, lit_exp_a);
          end
        end
        if (lit_use_b) begin
          checks++;
          if (got_b !== lit_exp_b) begin
            errors++;
            $display("FAIL %s inst B got %h exp %h", lit_name, got_b, lit_exp_b);
          end
        end
        lit_done = lit_seq;
      end
    end
  end

  // Queue a literal expectation for the next negedge and wait for it
  task automatic lit(input string nm, input logic ua, input logic [11:0] ea,
                     input logic ub, input logic [11:0] eb);
    lit_name  = nm;
    lit_use_a = ua; lit_exp_a = ea;
    lit_use_b = ub; lit_exp_b = eb;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a, input logic [2:0] s, input logic w, input logic [1:0] t);
    @(posedge clk);
    #1;
    hsel = 1'b1; haddr = a; hsize = s; hwrite = w; htrans = t;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    htrans = 2'd0; hwrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = 4'd0; hsize = 3'd0; htrans = 2'd0; hwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    lit("reset", 1'b1, 12'h8F0, 1'b1, 12'h8F0);

    // Word write @0
    issue(4'd0, 3'd2, 1'b1, 2'd2);
    idle();
    lit("word_wr0", 1'b1, 12'hB0F, 1'b1, 12'hB0F);
    lit("loc_back_none", 1'b1, 12'h8F0, 1'b1, 12'h8F0);

    // Back-to-back: byte read @5, halfword read @6
    issue(4'd5, 3'd0, 1'b0, 2'd2);
    issue(4'd6, 3'd1, 1'b0, 2'd3);
    lit("b2b_first", 1'b1, 12'hA62, 1'b1, 12'hA62);
    idle();
    lit("b2b_second", 1'b1, 12'hA7C, 1'b1, 12'hA7C);

    // Misaligned word read @2
    issue(4'd2, 3'd2, 1'b0, 2'd2);
    idle();
    lit("misal_err1", 1'b1, 12'h4F0, 1'b1, 12'h4F0);
    lit("misal_err2", 1'b1, 12'hCF0, 1'b1, 12'hCF0);
    lit("misal_after", 1'b1, 12'h8F0, 1'b1, 12'h8F0);

    // Byte write to read-only OCCUP @8
    issue(4'd8, 3'd0, 1'b1, 2'd2);
    idle();
    lit("ro_wr_1", 1'b1, 12'h4F0, 1'b1, 12'hAC1);
    lit("ro_wr_2", 1'b1, 12'hCF0, 1'b1, 12'h8F0);
    lit("ro_wr_3", 1'b1, 12'h8F0, 1'b1, 12'h8F0);

    // Unmapped @15
    issue(4'd15, 3'd0, 1'b0, 2'd2);
    idle();
    lit("unmapped_1", 1'b1, 12'h4F0, 1'b1, 12'h4F0);
    lit("unmapped_2", 1'b1, 12'hCF0, 1'b1, 12'hCF0);

    // Reset during ERR1
    issue(4'd15, 3'd0, 1'b1, 2'd2);
    idle();
    lit("pre_rst_err1", 1'b1, 12'h4F0, 1'b1, 12'h4F0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lit("rst_in_err1", 1'b1, 12'h8F0, 1'b1, 12'h8F0);

    // IDLE and BUSY with hsel: no request
    issue(4'd0, 3'd2, 1'b1, 2'd0);
    idle();
    lit("htrans_idle", 1'b1, 12'h8F0, 1'b1, 12'h8F0);
    issue(4'd12, 3'd0, 1'b1, 2'd1);
    idle();
    lit("htrans_busy", 1'b1, 12'h8F0, 1'b1, 12'h8F0);

    // New transfer accepted at the edge ending ERR2 (held through ERR1)
    issue(4'd2, 3'd2, 1'b0, 2'd2);
    issue(4'd1, 3'd0, 1'b1, 2'd2);
    issue(4'd1, 3'd0, 1'b1, 2'd2);
    idle();
    lit("accept_in_err2", 1'b1, 12'hB32, 1'b1, 12'hB32);
    repeat (3) idle();

    // Sweep of the whole address/size/direction space with gaps
    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < 4; s++) begin
        for (int w = 0; w < 2; w++) begin
          issue(4'(a), 3'(s), 1'(w), 2'd2);
          repeat (3) idle();
        end
      end
    end

    // Random back-to-back traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      rst    = ($urandom_range(0, 49) == 0);
      hsel   = ($urandom_range(0, 7) != 0);
      htrans = 2'($urandom_range(0, 3));
      haddr  = 4'($urandom_range(0, 15));
      hsize  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      hwrite = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    rst = 1'b0; hsel = 1'b0; htrans = 2'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
